// File: rtl/vga_frame_monitor_if.sv
// Video stream bundle observed by vga_frame_monitor: sync, blanking and RGB pixel data.
interface vga_frame_monitor_if;
   logic       hsync;
   logic       vsync;
   logic       hblank;
   logic       vblank;
   logic [7:0] r;
   logic [7:0] g;
   logic [7:0] b;

   modport master (output hsync, vsync, hblank, vblank, r, g, b);
   modport slave  (input  hsync, vsync, hblank, vblank, r, g, b);
endinterface

// File: rtl/vga_frame_monitor.sv
// Receive-side VGA monitor: learns sync polarity, measures line/frame timing,
// checksums visible pixels per frame and reports lock / signal-loss status.
module vga_frame_monitor #(
   parameter int unsigned TIMEOUT_LOG2 = 21
) (
   input  logic                clk,
   input  logic                rst_n,
   vga_frame_monitor_if.slave  vid,
   output logic                hsync_pol,
   output logic                vsync_pol,
   output logic [10:0]         h_total,
   output logic [10:0]         h_active,
   output logic [10:0]         h_sync,
   output logic [10:0]         v_total,
   output logic [10:0]         v_active,
   output logic [23:0]         checksum,
   output logic [7:0]          frame_count,
   output logic                frame_valid,
   output logic                locked,
   output logic                no_signal
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MEAS  = 2'd1;
   localparam logic [1:0] ST_TRACK = 2'd2;

   localparam logic [10:0]             CNT_MAX = '1;
   localparam logic [TIMEOUT_LOG2-1:0] TO_MAX  = '1;

   logic                    hs_r, vs_r, hb_r, vb_r;
   logic [23:0]             rgb_r;
   logic                    hs_d, vs_d, vis_d;
   logic                    inactive_h, inactive_v;
   logic [1:0]              state;
   logic [10:0]             hcnt, swcnt, viscnt, lcnt, vlines;
   logic [10:0]             h_len, ha_len, sw_len;
   logic [23:0]             cs;
   logic [TIMEOUT_LOG2-1:0] tcnt;

   logic        vis, vis_start, hs_act, vs_act, hs_start, hs_end, vs_start;
   logic        timeout, publish;
   logic [10:0] hcnt_nxt, swcnt_nxt, viscnt_nxt, lcnt_nxt, vlines_nxt;
   logic [10:0] h_len_nxt, ha_len_nxt, sw_len_nxt;
   logic [23:0] cs_nxt;

   function automatic logic [10:0] sat_inc(input logic [10:0] v);
      return (v == CNT_MAX) ? v : v + 11'd1;
   endfunction

   assign hsync_pol = ~inactive_h;
   assign vsync_pol = ~inactive_v;

   // Prior activity uses the current inactive level, so a polarity flip alone never forms an edge.
   always_comb begin
      vis       = ~hb_r & ~vb_r;
      vis_start = vis & ~vis_d;
      hs_act    = hs_r ^ inactive_h;
      vs_act    = vs_r ^ inactive_v;
      hs_start  = hs_act & ~(hs_d ^ inactive_h);
      hs_end    = ~hs_act & (hs_d ^ inactive_h);
      vs_start  = vs_act & ~(vs_d ^ inactive_v);
      timeout   = (tcnt == TO_MAX);
      publish   = vs_start & ((state == ST_MEAS) | (state == ST_TRACK));

      hcnt_nxt   = hs_start ? 11'd1 : sat_inc(hcnt);
      h_len_nxt  = hs_start ? hcnt : h_len;
      swcnt_nxt  = hs_act ? sat_inc(swcnt) : '0;
      sw_len_nxt = hs_end ? swcnt : sw_len;
      lcnt_nxt   = hs_start ? sat_inc(lcnt) : lcnt;
      ha_len_nxt = ha_len;
      vlines_nxt = vlines;
      viscnt_nxt = vis ? sat_inc(viscnt) : viscnt;
      if (hs_start) begin
         viscnt_nxt = vis ? 11'd1 : 11'd0;
         if (viscnt != '0) begin
            ha_len_nxt = viscnt;
            vlines_nxt = sat_inc(vlines);
         end
      end
      cs_nxt = vis ? ({cs[22:0], cs[23]} ^ rgb_r) : cs;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_r       <= 1'b1;
         vs_r       <= 1'b1;
         hb_r       <= 1'b1;
         vb_r       <= 1'b1;
         rgb_r      <= '0;
         hs_d       <= 1'b1;
         vs_d       <= 1'b1;
         vis_d      <= 1'b0;
         inactive_h <= 1'b1;
         inactive_v <= 1'b1;
      end else begin
         hs_r  <= vid.hsync;
         vs_r  <= vid.vsync;
         hb_r  <= vid.hblank;
         vb_r  <= vid.vblank;
         rgb_r <= {vid.r, vid.g, vid.b};
         hs_d  <= hs_r;
         vs_d  <= vs_r;
         vis_d <= vis;
         if (vis_start) begin
            inactive_h <= hs_r;
            inactive_v <= vs_r;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         hcnt        <= '0;
         swcnt       <= '0;
         viscnt      <= '0;
         lcnt        <= '0;
         vlines      <= '0;
         h_len       <= '0;
         ha_len      <= '0;
         sw_len      <= '0;
         cs          <= '0;
         tcnt        <= '0;
         h_total     <= '0;
         h_active    <= '0;
         h_sync      <= '0;
         v_total     <= '0;
         v_active    <= '0;
         checksum    <= '0;
         frame_count <= '0;
         frame_valid <= 1'b0;
         locked      <= 1'b0;
         no_signal   <= 1'b0;
      end else begin
         hcnt        <= hcnt_nxt;
         swcnt       <= swcnt_nxt;
         viscnt      <= viscnt_nxt;
         h_len       <= h_len_nxt;
         ha_len      <= ha_len_nxt;
         sw_len      <= sw_len_nxt;
         lcnt        <= lcnt_nxt;
         vlines      <= vlines_nxt;
         cs          <= cs_nxt;
         frame_valid <= 1'b0;

         // Publish from the *_nxt values so a coincident line end is folded in first.
         if (vs_start) begin
            lcnt      <= '0;
            vlines    <= '0;
            cs        <= '0;
            tcnt      <= '0;
            no_signal <= 1'b0;
            if (publish) begin
               h_total     <= h_len_nxt;
               h_active    <= ha_len_nxt;
               h_sync      <= sw_len_nxt;
               v_total     <= lcnt_nxt;
               v_active    <= vlines_nxt;
               checksum    <= cs_nxt;
               frame_valid <= 1'b1;
               frame_count <= frame_count + 8'd1;
            end
            if (state == ST_TRACK)
               locked <= (h_len_nxt == h_total) && (lcnt_nxt == v_total);
            state <= (state == ST_IDLE) ? ST_MEAS : ST_TRACK;
         end else if (timeout) begin
            state     <= ST_IDLE;
            no_signal <= 1'b1;
            locked    <= 1'b0;
         end else begin
            tcnt <= tcnt + 1'b1;
         end
      end
   end
endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Receive-side companion to the VGA pattern controller. It watches an `hsync`/`vsync`/`hblank`/`vblank`/RGB stream, either looped back from the controller's digital outputs or driven by a bench. From that stream it learns sync polarity, measures line and frame timing, and computes a per-frame checksum of visible pixels. It reports lock status and a one-cycle `frame_valid` strobe, so timing modes and pattern modes can be checked on silicon or in simulation without a capture card.

## Interface
Parameters:
- `TIMEOUT_LOG2`, 21: no `vsync` edge within 2^TIMEOUT_LOG2 cycles means the signal is lost.

Ports:
- `clk`  in  1  pixel clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `hsync`, `vsync`  in  1 each  sync inputs, either polarity.
- `hblank`, `vblank`  in  1 each  high during blanking.
- `r`, `g`, `b`  in  8 each  pixel data.
- `hsync_pol`, `vsync_pol`  out  1 each  learned active level (1 = active-high).
- `h_total`  out  11  cycles per line.
- `h_active`  out  11  visible cycles per line.
- `h_sync`  out  11  hsync active width.
- `v_total`  out  11  lines per frame.
- `v_active`  out  11  lines containing at least one visible cycle.
- `checksum`  out  24  visible-pixel checksum of the last frame.
- `frame_count`  out  8  completed frames; wraps 255→0.
- `frame_valid`  out  1  one-cycle strobe when the measurement outputs update.
- `locked`  out  1  timing stable.
- `no_signal`  out  1  timeout flag.

## Operation
- **Input stage.** All inputs are registered once. All logic below runs on the registered copies.
  - `vis = ~hblank & ~vblank`.
  - Prior-cycle copies are kept for edge detection.
- **Polarity.**
  - On the first `vis` cycle of each line (rising edge of `vis`), the current `hsync` and `vsync` levels are latched as their inactive levels.
  - The active level is the inverse; `hsync_pol`/`vsync_pol` output the active level.
  - Reset inactive level is 1 (active-low sync).
  - `hs_act = hsync ^ inactive_h`; `vs_act` is defined the same way.
  - `hs_start`/`vs_start` are the rising edges of `hs_act`/`vs_act`.
- **Line counters.** All counters are 11-bit and saturate at 2047.
  - `hcnt` increments every cycle.
  - On `hs_start`: latch `hcnt` into the line length, then set `hcnt = 1`.
  - `swcnt` counts `hs_act` cycles and is latched into the sync width when `hs_act` falls.
  - `viscnt` counts `vis` cycles. On `hs_start`: if nonzero, latch it as the line's active width, increment `vlines`, and clear it.
  - `hs_start` also increments `lcnt`.
  - A `vis` cycle coinciding with `hs_start` counts toward the new line.
- **Checksum.** Each `vis` cycle: `cs = {cs[22:0],cs[23]} ^ {r,g,b}`.
- **Frame end (`vs_start`).**
  - If `hs_start` occurs in the same cycle, the line update is applied first.
  - Then, in states MEAS and TRACK only, the measurement outputs load from the working values: `h_total`, `h_active` and `h_sync` from the last line; `v_total` = `lcnt`; `v_active` = `vlines`; `checksum` = `cs`.
  - Also in MEAS and TRACK: `frame_valid` pulses and `frame_count` increments.
  - In all states: `lcnt`, `vlines`, `cs` and the timeout counter clear.
- **State machine.** Reset state is IDLE.
  - IDLE → MEAS on `vs_start`. The partial first frame is discarded.
  - MEAS → TRACK on the next `vs_start`, after publishing.
  - In TRACK, each `vs_start` compares the new `h_total`/`v_total` with the previous published values. Equal sets `locked = 1`; unequal clears it.
  - Any state → IDLE when the timeout counter reaches 2^TIMEOUT_LOG2−1. This sets `no_signal = 1` and `locked = 0`.
  - `no_signal` clears on the next `vs_start`.
  - Published measurement values hold through a timeout.
- **Reset.** Every output is 0 except `no_signal`, which resets to 0 and `locked`, which resets to 0. Working counters are 0. Assertion mid-frame aborts immediately; there is no partial publish.

## Timing
- **Edge to strobe.** The raw `vsync` active edge is captured at clock edge k. `frame_valid` is high for the cycle after edge k+1, and outputs are stable from edge k+1.
- **Output stability.** Measurement outputs change only in the `frame_valid` cycle and hold otherwise.
- **Lock latency.** `locked` updates in the same cycle as `frame_valid`. The earliest `locked = 1` follows the third `vs_start` after reset.
- **Polarity.** A polarity change takes effect from the first visible cycle of the next line. The edge caused by the flip itself is not a `vs_start`/`hs_start`.

## Test plan
- **640×480@60 stream, negative sync:** 800 cycles/line, 96-cycle hsync, 640 visible; 525 lines, 2-line vsync, 480 visible. Response: `hsync_pol = 0`, `vsync_pol = 0`; `h_total` 800, `h_active` 640, `h_sync` 96, `v_total` 525, `v_active` 480. `locked` rises at the third `vs_start`; `frame_count` = 2 at that point.
- **Single-pixel checksum:** same timing, RGB = 0 except the first visible pixel = 0x000001. Response: `checksum` = 0x800000 (1 rotated through 307199 further steps). All-zero RGB → `checksum` 0.
- **Positive-polarity synthetic timing:** 100-cycle lines, 10-cycle active-high hsync, 80 visible; 20 lines, 16 visible. Response: `hsync_pol = 1`, `vsync_pol = 1`; measurements 100/80/10/20/16.
- **Timing change:** switch `h_total` 800→801 after lock. Response: at the next `frame_valid`, `locked` falls and `h_total` = 801. `locked` re-rises one frame later.
- **Sync removal:** hold `vsync` inactive for 2^21 cycles. Response: `no_signal = 1`, `locked = 0`, published values unchanged. Restoring sync clears `no_signal` at the first `vs_start`.
- **Reset:** assert `rst_n = 0` mid-frame. Response: all outputs 0 asynchronously. After release, no `frame_valid` until the second `vs_start`.
